data_path: RTL and testbench
============================

DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of bus, registers and ALU operands; Z is 2*DATA_WIDTH.
REQ-002 clk  in  1  single clock; every register updates on its rising edge.
REQ-003 clr  in  1  synchronous active-high reset.
REQ-004 GRin  in  16  one-hot-per-bit write enables for R0..R15.
REQ-005 GRout  in  16  read selects for R0..R15 onto the bus.
REQ-006 DPin  in  16  enables: PC=0, IR=1, Y=2, MAR=3, MDR=4, INPORT=5, OUTPORT=6, Z=7, HI=10, LO=11, READ=12 (MDR source select).
REQ-007 DPout  in  16  bus drivers: PC=0, MDR=4, INPORT=5, ZHI=8, ZLO=9, HI=10, LO=11.
REQ-008 ALUopp  in  16  op select: ADD=0, SUB=1, NEG=2, MUL=3, DIV=4, AND=5, OR=6, ROR=7, ROL=8, SLL=9, SRA=10, SRL=11, NOT=12, INC=13.
REQ-009 INPORTin  in  32  external input-port data; Mdatain  in  32  memory read data.
REQ-010 IRout, MARout, OUTPORTout, BusMuxInMDR  out  32 each  IR, MAR, OUTPORT and MDR register contents.

Function
REQ-011 Bus is combinational; driver priority, highest first: any GRout bit, HI, LO, ZHI, ZLO, PC, MDR, INPORT; no driver -> bus = 0.
REQ-012 GR read: lowest-index asserted GRout bit selects; R0 is an ordinary register.
REQ-013 GR write: every Ri with GRin[i]=1 loads the bus at the clock edge.
REQ-014 PC, IR, Y, MAR, OUTPORT, HI, LO load the bus when their DPin bit is 1; otherwise they hold.
REQ-015 MDR loads Mdatain when DPin[READ]=1, else loads the bus; loading is gated by DPin[MDR].
REQ-016 INPORT loads INPORTin when DPin[INPORT]=1.
REQ-017 Z (64-bit) loads the ALU result when DPin[Z]=1; ZHI = Z[63:32], ZLO = Z[31:0].
REQ-018 ALU is combinational: A = Y, B = bus; the lowest-index asserted ALUopp bit wins; no bit asserted -> result 0.
REQ-019 Non-MUL/DIV results go to Z[31:0] with Z[63:32]=0; ADD/SUB wrap modulo 2^32.
REQ-020 NEG = -B; NOT = ~B; INC = B+1; AND/OR are bitwise.
REQ-021 Shifts and rotates shift A by B[4:0]; SRA sign-fills; SRL zero-fills.
REQ-022 MUL = signed A*B, full 64-bit result; DIV: Z[31:0] = signed A/B (truncated), Z[63:32] = remainder with the sign of A.
REQ-023 Divide by zero: Z[31:0] = 0 and Z[63:32] = A.
REQ-024 A value driven onto the bus in cycle n is captured at the end of cycle n; Z holds result of the same cycle's Y and bus.

Reset
REQ-025 clr=1 at a rising edge clears R0-R15, PC, IR, Y, MAR, MDR, INPORT, OUTPORT, HI, LO and Z to 0, overriding all enables.
REQ-026 All outputs read 0 in the cycle after reset.

Configuration
REQ-027 Macro DATA_PATH_MULDIV_EN: when defined, MUL and DIV are implemented as in REQ-022/REQ-023; when undefined, the MUL and DIV selects produce Z = 0 and no multiplier/divider logic is synthesized.

Structure
REQ-028 A shared package holds the DPin/DPout bit-index constants, the ALU op index constants, and DATA_WIDTH.
REQ-029 The ALU is one sub-module, dp_alu; the registers, register file and bus mux are inline.

Verification
REQ-030 Load via MDR: Mdatain=0x22, DPin[READ,MDR]=1; next cycle DPout[MDR]=1, GRin[3]=1 -> R3=0x22; likewise R7=0x24, R4=0x28.
REQ-031 Fetch: PC=0; T0 DPout[PC], DPin[MAR,Z], INC -> MAR=0, Z=1; T1 ZLO->PC with READ/MDR and Mdatain=0x2A2B8000 -> PC=1; T2 MDR->IR -> IRout=0x2A2B8000.
REQ-032 AND R4,R3,R7: GRout[3]->Y; GRout[7] with AND into Z; ZLO->GRin[4] -> R4=0x20.
REQ-033 MUL, with DATA_PATH_MULDIV_EN defined: Y=0xFFFFFFFE (-2), bus=3 -> Z=0xFFFFFFFF_FFFFFFFA; DIV with Y=7, bus=-2 -> ZLO=0xFFFFFFFD, ZHI=1; DIV with bus=0 -> ZLO=0, ZHI=7.
REQ-034 SRA: Y=0x80000000, bus=4 -> ZLO=0xF8000000; ROL: Y=0x80000001, bus=1 -> ZLO=0x00000003.
REQ-035 Registers nonzero, then clr=1 for one edge with all enables high -> every register and output is 0.

Source files
------------

// File: rtl/data_path_pkg.sv
// Shared constants for the data path: bus width, DPin/DPout bit
// positions and ALU op-select bit positions.
package data_path_pkg;

    localparam int DATA_WIDTH = 32;

    localparam int DP_PC      = 0;
    localparam int DP_IR      = 1;
    localparam int DP_Y       = 2;
    localparam int DP_MAR     = 3;
    localparam int DP_MDR     = 4;
    localparam int DP_INPORT  = 5;
    localparam int DP_OUTPORT = 6;
    localparam int DP_Z       = 7;
    localparam int DP_ZHI     = 8;
    localparam int DP_ZLO     = 9;
    localparam int DP_HI      = 10;
    localparam int DP_LO      = 11;
    localparam int DP_READ    = 12;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_NEG = 2;
    localparam int ALU_MUL = 3;
    localparam int ALU_DIV = 4;
    localparam int ALU_AND = 5;
    localparam int ALU_OR  = 6;
    localparam int ALU_ROR = 7;
    localparam int ALU_ROL = 8;
    localparam int ALU_SLL = 9;
    localparam int ALU_SRA = 10;
    localparam int ALU_SRL = 11;
    localparam int ALU_NOT = 12;
    localparam int ALU_INC = 13;

endpackage

// File: rtl/data_path_if.sv
// Control/data bundle between the sequencer (master) and the data
// path (slave).
interface data_path_if
    import data_path_pkg::*;
#(
    parameter int W = DATA_WIDTH
);
    logic [15:0]  GRin;
    logic [15:0]  GRout;
    logic [15:0]  DPin;
    logic [15:0]  DPout;
    logic [15:0]  ALUopp;
    logic [W-1:0] INPORTin;
    logic [W-1:0] Mdatain;
    logic [W-1:0] IRout;
    logic [W-1:0] MARout;
    logic [W-1:0] OUTPORTout;
    logic [W-1:0] BusMuxInMDR;

    modport master (
        output GRin, GRout, DPin, DPout, ALUopp,
        output INPORTin, Mdatain,
        input  IRout, MARout, OUTPORTout, BusMuxInMDR
    );

    modport slave (
        input  GRin, GRout, DPin, DPout, ALUopp,
        input  INPORTin, Mdatain,
        output IRout, MARout, OUTPORTout, BusMuxInMDR
    );
endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU, A = Y and B = bus, lowest asserted op bit wins.
// MUL/DIV exist only when DATA_PATH_MULDIV_EN is defined.
module dp_alu
    import data_path_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [15:0]    i_op,
    output logic [2*W-1:0] o_result
);
    localparam int SW = $clog2(W);

    logic [SW-1:0]  w_sh;
    logic [2*W-1:0] w_rot_r;
    logic [2*W-1:0] w_rot_l;
    logic [2*W-1:0] w_mul;
    logic [2*W-1:0] w_div;
    logic [W-1:0]   w_zero;

    assign w_sh    = i_b[SW-1:0];
    assign w_zero  = '0;
    // Rotates via a doubled copy of A so a zero amount needs no special case
    assign w_rot_r = {i_a, i_a} >> w_sh;
    assign w_rot_l = {i_a, i_a} << w_sh;

`ifdef DATA_PATH_MULDIV_EN
    logic signed [2*W-1:0] w_prod;
    logic signed [W-1:0]   w_quo;
    logic signed [W-1:0]   w_rem;

    assign w_prod = $signed(i_a) * $signed(i_b);
    assign w_quo  = $signed(i_a) / $signed(i_b);
    assign w_rem  = $signed(i_a) % $signed(i_b);
    assign w_mul  = w_prod;
    assign w_div  = (i_b == w_zero) ? {i_a, w_zero}
                                    : {w_rem, w_quo};
`else
    assign w_mul = '0;
    assign w_div = '0;
`endif

    always_comb begin
        o_result = '0;
        priority case (1'b1)
            i_op[ALU_ADD]: o_result = {w_zero, i_a + i_b};
            i_op[ALU_SUB]: o_result = {w_zero, i_a - i_b};
            i_op[ALU_NEG]: o_result = {w_zero, -i_b};
            i_op[ALU_MUL]: o_result = w_mul;
            i_op[ALU_DIV]: o_result = w_div;
            i_op[ALU_AND]: o_result = {w_zero, i_a & i_b};
            i_op[ALU_OR]:  o_result = {w_zero, i_a | i_b};
            i_op[ALU_ROR]: o_result = {w_zero, w_rot_r[W-1:0]};
            i_op[ALU_ROL]: o_result = {w_zero, w_rot_l[2*W-1:W]};
            i_op[ALU_SLL]: o_result = {w_zero, i_a << w_sh};
            i_op[ALU_SRA]: o_result = {w_zero, W'($signed(i_a) >>> w_sh)};
            i_op[ALU_SRL]: o_result = {w_zero, i_a >> w_sh};
            i_op[ALU_NOT]: o_result = {w_zero, ~i_b};
            i_op[ALU_INC]: o_result = {w_zero, i_b + W'(1)};
            default:       o_result = '0;
        endcase
    end
endmodule

// File: rtl/data_path.sv
// Single-bus data path: register file, special registers, bus mux, ALU.
// Optional MUL/DIV hardware is enabled by DATA_PATH_MULDIV_EN.
module data_path
    import data_path_pkg::*;
#(
    parameter int DATA_WIDTH = data_path_pkg::DATA_WIDTH
) (
    input logic        clk,
    input logic        clr,
    data_path_if.slave bus_if
);
    localparam int W = DATA_WIDTH;

    logic [W-1:0]   r_gr [16];
    logic [W-1:0]   r_pc;
    logic [W-1:0]   r_ir;
    logic [W-1:0]   r_y;
    logic [W-1:0]   r_mar;
    logic [W-1:0]   r_mdr;
    logic [W-1:0]   r_inport;
    logic [W-1:0]   r_outport;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [2*W-1:0] r_z;

    logic [W-1:0]   w_gr_rd;
    logic [W-1:0]   w_bus;
    logic [2*W-1:0] w_alu;
    logic [W-1:0]   w_zhi;
    logic [W-1:0]   w_zlo;

    assign w_zhi = r_z[2*W-1:W];
    assign w_zlo = r_z[W-1:0];

    // Scan downward so the lowest-index select is the one that sticks
    always_comb begin
        w_gr_rd = '0;
        for (int i = 15; i >= 0; i--) begin
            if (bus_if.GRout[i]) begin
                w_gr_rd = r_gr[i];
            end
        end
    end

    always_comb begin
        w_bus = '0;
        if (|bus_if.GRout) begin
            w_bus = w_gr_rd;
        end else if (bus_if.DPout[DP_HI]) begin
            w_bus = r_hi;
        end else if (bus_if.DPout[DP_LO]) begin
            w_bus = r_lo;
        end else if (bus_if.DPout[DP_ZHI]) begin
            w_bus = w_zhi;
        end else if (bus_if.DPout[DP_ZLO]) begin
            w_bus = w_zlo;
        end else if (bus_if.DPout[DP_PC]) begin
            w_bus = r_pc;
        end else if (bus_if.DPout[DP_MDR]) begin
            w_bus = r_mdr;
        end else if (bus_if.DPout[DP_INPORT]) begin
            w_bus = r_inport;
        end
    end

    dp_alu #(
        .W (W)
    ) u_alu (
        .i_a      (r_y),
        .i_b      (w_bus),
        .i_op     (bus_if.ALUopp),
        .o_result (w_alu)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                r_gr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (bus_if.GRin[i]) begin
                    r_gr[i] <= w_bus;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_y       <= '0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_inport  <= '0;
            r_outport <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_z       <= '0;
        end else begin
            if (bus_if.DPin[DP_PC])      r_pc      <= w_bus;
            if (bus_if.DPin[DP_IR])      r_ir      <= w_bus;
            if (bus_if.DPin[DP_Y])       r_y       <= w_bus;
            if (bus_if.DPin[DP_MAR])     r_mar     <= w_bus;
            if (bus_if.DPin[DP_OUTPORT]) r_outport <= w_bus;
            if (bus_if.DPin[DP_HI])      r_hi      <= w_bus;
            if (bus_if.DPin[DP_LO])      r_lo      <= w_bus;
            if (bus_if.DPin[DP_INPORT])  r_inport  <= bus_if.INPORTin;
            if (bus_if.DPin[DP_Z])       r_z       <= w_alu;
            if (bus_if.DPin[DP_MDR]) begin
                r_mdr <= bus_if.DPin[DP_READ] ? bus_if.Mdatain : w_bus;
            end
        end
    end

    assign bus_if.IRout       = r_ir;
    assign bus_if.MARout      = r_mar;
    assign bus_if.OUTPORTout  = r_outport;
    assign bus_if.BusMuxInMDR = r_mdr;
endmodule

// File: tb/tb_data_path.sv
// Directed-vector bench for data_path; internal registers are observed
// by routing them through OUTPORT.
module tb_data_path;
    import data_path_pkg::*;

    logic clk = 1'b0;
    logic clr;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    data_path_if dif ();

    data_path dut (
        .clk    (clk),
        .clr    (clr),
        .bus_if (dif)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        dif.GRin     = '0;
        dif.GRout    = '0;
        dif.DPin     = '0;
        dif.DPout    = '0;
        dif.ALUopp   = '0;
        dif.INPORTin = '0;
        dif.Mdatain  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic show_gr(input int i, input logic [31:0] exp,
                           input string tag);
        dif.GRout[i]          = 1'b1;
        dif.DPin[DP_OUTPORT]  = 1'b1;
        tick();
        chk(tag, 64'(dif.OUTPORTout), 64'(exp));
    endtask

    task automatic show_dp(input logic [15:0] outs, input logic [31:0] exp,
                           input string tag);
        dif.DPout             = outs;
        dif.DPin[DP_OUTPORT]  = 1'b1;
        tick();
        chk(tag, 64'(dif.OUTPORTout), 64'(exp));
    endtask

    task automatic put(input int dst, input logic [31:0] v);
        dif.INPORTin        = v;
        dif.DPin[DP_INPORT] = 1'b1;
        tick();
        dif.DPout[DP_INPORT] = 1'b1;
        dif.DPin[dst]        = 1'b1;
        tick();
    endtask

    task automatic load_gr(input int i, input logic [31:0] v);
        dif.Mdatain       = v;
        dif.DPin[DP_READ] = 1'b1;
        dif.DPin[DP_MDR]  = 1'b1;
        tick();
        dif.DPout[DP_MDR] = 1'b1;
        dif.GRin[i]       = 1'b1;
        tick();
    endtask

    task automatic alu(input string tag, input logic [31:0] y,
                       input logic [31:0] b, input logic [15:0] op,
                       input logic [63:0] exp);
        put(DP_Y, y);
        dif.INPORTin        = b;
        dif.DPin[DP_INPORT] = 1'b1;
        tick();
        dif.DPout[DP_INPORT] = 1'b1;
        dif.ALUopp           = op;
        dif.DPin[DP_Z]       = 1'b1;
        tick();
        show_dp(16'(1 << DP_ZLO), exp[31:0],  {tag, ".lo"});
        show_dp(16'(1 << DP_ZHI), exp[63:32], {tag, ".hi"});
    endtask

    function automatic logic [15:0] op1(input int i);
        return 16'(1 << i);
    endfunction

    initial begin
        logic [63:0] e_mul, e_div, e_div0;
`ifdef DATA_PATH_MULDIV_EN
        e_mul  = 64'hFFFFFFFF_FFFFFFFA;
        e_div  = 64'h00000001_FFFFFFFD;
        e_div0 = 64'h00000007_00000000;
`else
        e_mul  = 64'h0;
        e_div  = 64'h0;
        e_div0 = 64'h0;
`endif
        idle();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        chk("rst.ir",  64'(dif.IRout),       64'h0);
        chk("rst.mar", 64'(dif.MARout),      64'h0);
        chk("rst.out", 64'(dif.OUTPORTout),  64'h0);
        chk("rst.mdr", 64'(dif.BusMuxInMDR), 64'h0);

        load_gr(3, 32'h22);
        chk("mdr.ld", 64'(dif.BusMuxInMDR), 64'h22);
        load_gr(7, 32'h24);
        load_gr(4, 32'h28);
        show_gr(3, 32'h22, "r3");
        show_gr(7, 32'h24, "r7");
        show_gr(4, 32'h28, "r4");

        // fetch: T0..T2
        dif.DPout[DP_PC]   = 1'b1;
        dif.DPin[DP_MAR]   = 1'b1;
        dif.DPin[DP_Z]     = 1'b1;
        dif.ALUopp         = op1(ALU_INC);
        tick();
        chk("t0.mar", 64'(dif.MARout), 64'h0);
        dif.DPout[DP_ZLO]  = 1'b1;
        dif.DPin[DP_PC]    = 1'b1;
        dif.DPin[DP_READ]  = 1'b1;
        dif.DPin[DP_MDR]   = 1'b1;
        dif.Mdatain        = 32'h2A2B8000;
        tick();
        chk("t1.mdr", 64'(dif.BusMuxInMDR), 64'h2A2B8000);
        dif.DPout[DP_MDR]  = 1'b1;
        dif.DPin[DP_IR]    = 1'b1;
        tick();
        chk("t2.ir", 64'(dif.IRout), 64'h2A2B8000);
        show_dp(op1(DP_PC), 32'h1, "pc.inc");

        // AND R4,R3,R7
        dif.GRout[3]    = 1'b1;
        dif.DPin[DP_Y]  = 1'b1;
        tick();
        dif.GRout[7]    = 1'b1;
        dif.ALUopp      = op1(ALU_AND);
        dif.DPin[DP_Z]  = 1'b1;
        tick();
        dif.DPout[DP_ZLO] = 1'b1;
        dif.GRin[4]       = 1'b1;
        tick();
        show_gr(4, 32'h20, "and.r4");

        // bus priority
        put(DP_HI, 32'h11111111);
        put(DP_LO, 32'h22222222);
        show_dp(op1(DP_HI) | op1(DP_LO) | op1(DP_ZLO), 32'h11111111, "pri.hi");
        show_dp(op1(DP_LO) | op1(DP_ZLO) | op1(DP_PC), 32'h22222222, "pri.lo");
        dif.GRout[7] = 1'b1;
        show_gr(3, 32'h22, "pri.grlow");
        dif.DPout[DP_HI] = 1'b1;
        show_gr(7, 32'h24, "pri.gr");
        show_dp(16'h0, 32'h0, "pri.none");

        alu("add",   32'd5,        32'd7,        op1(ALU_ADD), 64'd12);
        alu("wrap",  32'hFFFFFFFF, 32'd2,        op1(ALU_ADD), 64'd1);
        alu("sub",   32'd3,        32'd5,        op1(ALU_SUB), 64'hFFFFFFFE);
        alu("neg",   32'd9,        32'd1,        op1(ALU_NEG), 64'hFFFFFFFF);
        alu("or",    32'hF0,       32'h0F,       op1(ALU_OR),  64'hFF);
        alu("ror",   32'h1,        32'h1,        op1(ALU_ROR), 64'h80000000);
        alu("rol",   32'h80000001, 32'h1,        op1(ALU_ROL), 64'h3);
        alu("sll",   32'h1,        32'd33,       op1(ALU_SLL), 64'h2);
        alu("sra",   32'h80000000, 32'd4,        op1(ALU_SRA), 64'hF8000000);
        alu("srl",   32'h80000000, 32'd4,        op1(ALU_SRL), 64'h08000000);
        alu("not",   32'h5,        32'h0,        op1(ALU_NOT), 64'hFFFFFFFF);
        alu("inc",   32'h5,        32'hFFFFFFFF, op1(ALU_INC), 64'h0);
        alu("prio1", 32'd5,        32'd3,
            op1(ALU_SUB) | op1(ALU_ADD), 64'd8);
        alu("prio2", 32'hF0,       32'h0F,
            op1(ALU_NOT) | op1(ALU_OR), 64'hFF);
        alu("noop",  32'd5,        32'd3,        16'h8000,     64'h0);
        alu("mul",   32'hFFFFFFFE, 32'd3,        op1(ALU_MUL), e_mul);
        alu("div",   32'd7,        32'hFFFFFFFE, op1(ALU_DIV), e_div);
        alu("div0",  32'd7,        32'd0,        op1(ALU_DIV), e_div0);

        // reset overrides every enable
        put(DP_MAR, 32'h55);
        put(DP_PC, 32'h77);
        clr          = 1'b1;
        dif.GRin     = '1;
        dif.GRout    = '1;
        dif.DPin     = '1;
        dif.DPout    = '1;
        dif.ALUopp   = op1(ALU_INC);
        dif.Mdatain  = 32'hFFFFFFFF;
        dif.INPORTin = 32'hFFFFFFFF;
        tick();
        clr = 1'b0;
        chk("clr.ir",  64'(dif.IRout),       64'h0);
        chk("clr.mar", 64'(dif.MARout),      64'h0);
        chk("clr.out", 64'(dif.OUTPORTout),  64'h0);
        chk("clr.mdr", 64'(dif.BusMuxInMDR), 64'h0);
        show_gr(3, 32'h0, "clr.r3");
        show_dp(op1(DP_PC),     32'h0, "clr.pc");
        show_dp(op1(DP_HI),     32'h0, "clr.hi");
        show_dp(op1(DP_ZLO),    32'h0, "clr.zlo");
        show_dp(op1(DP_INPORT), 32'h0, "clr.inport");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
